// File: rtl/lsu_bus_bridge.sv
// Bridge from the core's single-cycle data port to a valid/ready SoC bus with variable wait states.
// Optional bus watchdog: define LSU_BRIDGE_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES cycles.
module lsu_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_i_req,
    input  logic [31:0] lsu_i_daddr,
    input  logic [3:0]  lsu_i_dwmask,
    input  logic [31:0] lsu_i_dwdata,
    output logic [31:0] lsu_o_drdata,
    output logic        lsu_o_stall,
    output logic        lsu_o_err,
    output logic        bus_o_valid,
    input  logic        bus_i_ready,
    output logic [31:0] bus_o_addr,
    output logic        bus_o_we,
    output logic [3:0]  bus_o_be,
    output logic [31:0] bus_o_wdata,
    input  logic        bus_i_rvalid,
    input  logic [31:0] bus_i_rdata,
    input  logic        bus_i_rerr
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t state;
    logic   flushed;
    logic   abort;
    logic   resp_done;
    logic   tmo_hit;
    logic   timed_out;
    logic   unused_addr_bits;

    assign unused_addr_bits = ^lsu_i_daddr[1:0];

`ifdef LSU_BRIDGE_TIMEOUT_EN
    logic [15:0] wait_cnt;
    assign timed_out = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign timed_out      = 1'b0;
`endif

    // A flushed access still runs to completion on the bus but its result never reaches the core.
    assign abort     = flushed | ~lsu_i_req;
    assign resp_done = ((state == REQ) & bus_i_ready & bus_i_rvalid) |
                       ((state == RESP) & bus_i_rvalid);
    assign tmo_hit   = ((state == REQ) | (state == RESP)) & timed_out & ~resp_done;

    assign lsu_o_stall = lsu_i_req & (state != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            flushed      <= 1'b0;
            bus_o_valid  <= 1'b0;
            bus_o_we     <= 1'b0;
            bus_o_be     <= 4'b0000;
            bus_o_addr   <= 32'h0;
            bus_o_wdata  <= 32'h0;
            lsu_o_drdata <= 32'h0;
            lsu_o_err    <= 1'b0;
`ifdef LSU_BRIDGE_TIMEOUT_EN
            wait_cnt     <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_i_req) begin
                        bus_o_addr  <= {lsu_i_daddr[31:2], 2'b00};
                        bus_o_we    <= |lsu_i_dwmask;
                        bus_o_be    <= (|lsu_i_dwmask) ? lsu_i_dwmask : 4'b1111;
                        bus_o_wdata <= lsu_i_dwdata;
                        bus_o_valid <= 1'b1;
                        flushed     <= 1'b0;
                        state       <= REQ;
`ifdef LSU_BRIDGE_TIMEOUT_EN
                        wait_cnt    <= 16'd0;
`endif
                    end
                end
                REQ, RESP: begin
                    flushed <= abort;
`ifdef LSU_BRIDGE_TIMEOUT_EN
                    wait_cnt <= wait_cnt + 16'd1;
`endif
                    // A response arriving in the last allowed cycle wins over the watchdog.
                    if (resp_done || tmo_hit) begin
                        bus_o_valid <= 1'b0;
                        state       <= abort ? IDLE : DONE;
                        if (!abort) begin
                            if (tmo_hit) begin
                                lsu_o_err    <= 1'b1;
                                lsu_o_drdata <= 32'h0;
                            end else begin
                                lsu_o_err <= bus_i_rerr;
                                if (!bus_o_we) begin
                                    lsu_o_drdata <= bus_i_rdata;
                                end
                            end
                        end
                    end else if ((state == REQ) && bus_i_ready) begin
                        bus_o_valid <= 1'b0;
                        state       <= RESP;
                    end
                end
                DONE: begin
                    lsu_o_err <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge: transaction-level reference model, randomized bus timing.
// Define LSU_BRIDGE_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=4.
module tb_lsu_bus_bridge;

`ifdef LSU_BRIDGE_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 1 << 20;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_i_req;
    logic [31:0] lsu_i_daddr;
    logic [3:0]  lsu_i_dwmask;
    logic [31:0] lsu_i_dwdata;
    logic [31:0] lsu_o_drdata;
    logic        lsu_o_stall;
    logic        lsu_o_err;
    logic        bus_o_valid;
    logic        bus_i_ready;
    logic [31:0] bus_o_addr;
    logic        bus_o_we;
    logic [3:0]  bus_o_be;
    logic [31:0] bus_o_wdata;
    logic        bus_i_rvalid;
    logic [31:0] bus_i_rdata;
    logic        bus_i_rerr;

    always #5 clk = ~clk;

`ifdef LSU_BRIDGE_TIMEOUT_EN
    lsu_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
`else
    lsu_bus_bridge dut (
`endif
        .clk(clk), .rst(rst),
        .lsu_i_req(lsu_i_req), .lsu_i_daddr(lsu_i_daddr),
        .lsu_i_dwmask(lsu_i_dwmask), .lsu_i_dwdata(lsu_i_dwdata),
        .lsu_o_drdata(lsu_o_drdata), .lsu_o_stall(lsu_o_stall), .lsu_o_err(lsu_o_err),
        .bus_o_valid(bus_o_valid), .bus_i_ready(bus_i_ready), .bus_o_addr(bus_o_addr),
        .bus_o_we(bus_o_we), .bus_o_be(bus_o_be), .bus_o_wdata(bus_o_wdata),
        .bus_i_rvalid(bus_i_rvalid), .bus_i_rdata(bus_i_rdata), .bus_i_rerr(bus_i_rerr)
    );

    int total = 0;
    int bad   = 0;

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_valid, exp_err, exp_we;
    logic [31:0] exp_drdata, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] m_drdata;

    logic [31:0] cap_addr, cap_wdata, cap_drdata;
    logic        cap_we;
    logic [3:0]  cap_be;
    int          valid_cnt, stall_cnt, err_cnt;

    task automatic checkLit(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic checkOutput();
        checkLit("stall", 32'(lsu_o_stall), 32'(exp_stall));
        checkLit("valid", 32'(bus_o_valid), 32'(exp_valid));
        checkLit("err", 32'(lsu_o_err), 32'(exp_err));
        checkLit("drdata", lsu_o_drdata, exp_drdata);
        if (exp_valid) begin
            checkLit("addr", bus_o_addr, exp_addr);
            checkLit("we", 32'(bus_o_we), 32'(exp_we));
            checkLit("be", 32'(bus_o_be), 32'(exp_be));
            checkLit("wdata", bus_o_wdata, exp_wdata);
        end
    endtask

    // Compare process: samples 2 time units after each falling edge, once stimulus has settled.
    always begin
        @(negedge clk);
        #2;
        if (chk_en) checkOutput();
    end

    task automatic applyStimulus(input logic rq, input logic [31:0] a, input logic [3:0] m,
                                 input logic [31:0] wd, input logic rdy, input logic rv,
                                 input logic [31:0] rd, input logic re);
        lsu_i_req    = rq;
        lsu_i_daddr  = a;
        lsu_i_dwmask = m;
        lsu_i_dwdata = wd;
        bus_i_ready  = rdy;
        bus_i_rvalid = rv;
        bus_i_rdata  = rd;
        bus_i_rerr   = re;
    endtask

    task automatic setIdle();
        exp_stall  = 1'b0;
        exp_valid  = 1'b0;
        exp_err    = 1'b0;
        exp_drdata = m_drdata;
    endtask

    task automatic capture();
        #3;
        if (bus_o_valid) begin
            cap_addr  = bus_o_addr;
            cap_we    = bus_o_we;
            cap_be    = bus_o_be;
            cap_wdata = bus_o_wdata;
            valid_cnt++;
        end
        if (lsu_o_stall) stall_cnt++;
        if (lsu_o_err) err_cnt++;
        cap_drdata = lsu_o_drdata;
    endtask

    // One core access. Window k=0 is the IDLE cycle with req raised; ready comes in REQ window
    // r+1, the response d windows later; the core sees the result in the window after completion.
    task automatic runAccess(input logic [31:0] a, input logic [3:0] m, input logic [31:0] wd,
                             input int r, input int d, input logic [31:0] rd, input logic re,
                             input int flush_at, input int gap);
        int c, endw, last;
        bit tmo, fl;
        logic rq, rdy, rv;
        c    = r + 1 + d;
        tmo  = (c > TMO);
        endw = tmo ? TMO : c;
        fl   = (flush_at != 0);
        last = fl ? endw : endw + 1;
        exp_addr  = {a[31:2], 2'b00};
        exp_we    = |m;
        exp_be    = exp_we ? m : 4'hF;
        exp_wdata = wd;
        valid_cnt = 0;
        stall_cnt = 0;
        err_cnt   = 0;
        cap_addr  = 32'h0;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            rq = !(fl && k >= flush_at);
            if (k >= 1 && k <= r + 1 && k <= endw) rdy = (k == r + 1);
            else rdy = 1'($urandom_range(0, 1));
            if (k == c && !tmo) rv = 1'b1;
            else if (k >= r + 1 && k <= endw) rv = 1'b0;
            else rv = 1'($urandom_range(0, 1));
            applyStimulus(rq, (k == 0) ? a : $urandom, (k == 0) ? m : 4'($urandom),
                          (k == 0) ? wd : $urandom, rdy, rv,
                          (k == c) ? rd : $urandom, (k == c) ? re : 1'($urandom));
            exp_stall = rq && (k != endw + 1);
            exp_valid = (k >= 1 && k <= r + 1 && k <= endw);
            exp_err   = 1'b0;
            if (k == endw + 1) begin
                exp_err = tmo ? 1'b1 : re;
                if (tmo) m_drdata = 32'h0;
                else if (!exp_we) m_drdata = rd;
            end
            exp_drdata = m_drdata;
            capture();
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            applyStimulus(1'b0, $urandom, 4'($urandom), $urandom, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom, 1'($urandom));
            setIdle();
            capture();
        end
    endtask

    initial begin
        int r, d, c, endw, fl_at;
        logic [3:0] m;
        rst = 1'b1;
        m_drdata = 32'h0;
        applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        setIdle();
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait load
        runAccess(32'h0000_1006, 4'h0, 32'h0, 0, 0, 32'hA1B2_C3D4, 1'b0, 0, 1);
        checkLit("t1_addr", cap_addr, 32'h0000_1004);
        checkLit("t1_be", 32'(cap_be), 32'hF);
        checkLit("t1_we", 32'(cap_we), 32'h0);
        checkLit("t1_stall_cycles", 32'(stall_cnt), 32'd2);
        checkLit("t1_drdata", cap_drdata, 32'hA1B2_C3D4);

        // Store with wait states
`ifdef LSU_BRIDGE_TIMEOUT_EN
        runAccess(32'h0000_2002, 4'hC, 32'h5566_0000, 2, 1, 32'h1234_5678, 1'b0, 0, 1);
        checkLit("t2_valid_cycles", 32'(valid_cnt), 32'd3);
`else
        runAccess(32'h0000_2002, 4'hC, 32'h5566_0000, 3, 2, 32'h1234_5678, 1'b0, 0, 1);
        checkLit("t2_valid_cycles", 32'(valid_cnt), 32'd4);
`endif
        checkLit("t2_we", 32'(cap_we), 32'h1);
        checkLit("t2_be", 32'(cap_be), 32'hC);
        checkLit("t2_wdata", cap_wdata, 32'h5566_0000);
        checkLit("t2_drdata_held", cap_drdata, 32'hA1B2_C3D4);

        // Bus error pulse, then a clean access
        runAccess(32'h0000_0010, 4'h0, 32'h0, 1, 0, 32'hCAFE_F00D, 1'b1, 0, 0);
        checkLit("t3_err_cycles", 32'(err_cnt), 32'd1);
        runAccess(32'h0000_0014, 4'h0, 32'h0, 0, 1, 32'h0BAD_BEEF, 1'b0, 0, 1);
        checkLit("t3_next_err_cycles", 32'(err_cnt), 32'd0);

        // Flush during RESP, then a normal access at 0x3000
        runAccess(32'h0000_2000, 4'h0, 32'h0, 1, 3, 32'h7777_7777, 1'b1, 3, 0);
        checkLit("t4_flush_stall", 32'(stall_cnt), 32'd3);
        checkLit("t4_flush_drdata", cap_drdata, 32'h0BAD_BEEF);
        checkLit("t4_flush_err", 32'(err_cnt), 32'd0);
        runAccess(32'h0000_3000, 4'h0, 32'h0, 0, 0, 32'h3000_0001, 1'b0, 0, 1);
        checkLit("t4_next_addr", cap_addr, 32'h0000_3000);
        checkLit("t4_next_drdata", cap_drdata, 32'h3000_0001);

        // Reset while in REQ, followed by a stray response
        @(negedge clk);
        applyStimulus(1'b1, 32'h0000_4000, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        setIdle();
        exp_stall = 1'b1;
        exp_addr = 32'h0000_4000; exp_we = 1'b0; exp_be = 4'hF; exp_wdata = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        setIdle();
        exp_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_drdata = 32'h0;
        applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        setIdle();
        capture();
        checkLit("t5_valid_dropped", 32'(bus_o_valid), 32'h0);
        runAccess(32'h0, 4'h0, 32'h0, 0, 0, 32'h0, 1'b0, 0, 0);
        repeat (2) begin
            @(negedge clk);
            applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
            setIdle();
            capture();
        end
        checkLit("t5_stray_drdata", cap_drdata, 32'h0);

`ifdef LSU_BRIDGE_TIMEOUT_EN
        // Ready never arrives: watchdog fires after 4 wait cycles
        runAccess(32'h0000_5000, 4'h0, 32'h0, 10, 0, 32'h5555_5555, 1'b0, 0, 2);
        checkLit("t6_tmo_err", 32'(err_cnt), 32'd1);
        checkLit("t6_tmo_valid", 32'(valid_cnt), 32'd4);
        checkLit("t6_tmo_drdata", cap_drdata, 32'h0);
`endif

        // Randomized accesses: loads/stores, wait states, flushes, back-to-back
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 5);
            d = $urandom_range(0, 4);
            c = r + 1 + d;
            endw = (c > TMO) ? TMO : c;
            fl_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, endw) : 0;
            m = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            runAccess($urandom, m, $urandom, r, d, $urandom, 1'($urandom_range(0, 3) == 0),
                      fl_at, $urandom_range(0, 2));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
